// File: rtl/gnf_phase_gen_pkg.sv
// Shared constants and helpers for the N-phase sequence generator.
// The helpers work on a fixed maximum width, so any PHASES up to
// GNF_MAX_PHASES can reuse them without a parameterised package.
package gnf_pkg;

    localparam int GNF_MAX_PHASES = 32;

    // Sequence mode: Johnson walks 2*PHASES steps, ring walks PHASES steps.
    localparam logic GNF_JOHNSON = 1'b0;
    localparam logic GNF_RING    = 1'b1;

    // Rotation direction.
    localparam logic GNF_FWD = 1'b0;
    localparam logic GNF_REV = 1'b1;

    // Number of steps in one full electrical cycle for the given mode.
    function automatic int gnf_steps(input int phases, input logic mode);
        return (mode == GNF_RING) ? phases : 2 * phases;
    endfunction

    // Phase pattern for a given step index. The pattern is always decoded
    // from the index, so an out-of-family pattern can never be produced.
    function automatic logic [GNF_MAX_PHASES-1:0] gnf_decode(input int phases,
                                                             input int sector,
                                                             input logic mode);
        logic [GNF_MAX_PHASES-1:0] pattern;
        pattern = '0;
        for (int i = 0; i < GNF_MAX_PHASES; i++) begin
            if (i < phases) begin
                if (mode == GNF_RING) begin
                    pattern[i] = (sector == i);
                end else begin
                    pattern[i] = (sector > i) && (sector <= i + phases);
                end
            end
        end
        return pattern;
    endfunction

endpackage

// File: rtl/gnf_phase_gen_if.sv
// Control and status bundle of the N-phase generator.
// The master side drives run/direction/mode/divider and observes the
// phase outputs; the slave side is the generator itself.
interface gnf_phase_gen_if #(
    parameter int PHASES = 3,
    parameter int DIV_W  = 8
);

    localparam int SEC_W = $clog2(2 * PHASES);

    logic             en;
    logic             dir;
    logic             mode;
    logic [DIV_W-1:0] div;
    logic [PHASES-1:0] q;
    logic [PHASES-1:0] qn;
    logic [SEC_W-1:0] sector;
    logic             step;
    logic             sync;

    modport master (
        output en, dir, mode, div,
        input  q, qn, sector, step, sync
    );

    modport slave (
        input  en, dir, mode, div,
        output q, qn, sector, step, sync
    );

endinterface

// File: rtl/gnf_phase_gen_prescaler.sv
// Enable-gated prescaler: produces a tick on every DIV+1 enabled clocks.
// Comparing with >= rather than == means a divider lowered below the
// running count takes effect on the very next enabled clock.
module gnf_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             se,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt >= div);

    // Count enabled clocks, restart after each tick; clr restarts the count
    // regardless of enable so a mode switch begins from a clean period.
    always_ff @(posedge se) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/gnf_phase_gen.sv
// N-phase square-wave sequence generator.
// Holds the registered mode, the step index (up/down wrap counter), the
// decoded phase register and the STEP/SYNC pulse flops. The phase pattern
// is loaded on the same edge as the new step index, so Q has no extra
// latency relative to SECTOR.
module gnf_phase_gen #(
    parameter int PHASES = 3,
    parameter int DIV_W  = 8
) (
    input logic           se,
    input logic           rst,
    gnf_phase_gen_if.slave bus
);

    import gnf_pkg::*;

    localparam int SEC_W = $clog2(2 * PHASES);

    logic              mode_q;
    logic [SEC_W-1:0]  sector_q;
    logic [SEC_W-1:0]  sector_next;
    logic [SEC_W-1:0]  last_sector;
    logic [PHASES-1:0] q_q;
    logic [PHASES-1:0] q_next;
    logic [PHASES-1:0] q_home;
    logic              step_q;
    logic              sync_q;
    logic              tick;
    logic              mode_change;

    // A mode request differing from the active mode restarts the sequence.
    assign mode_change = (bus.mode != mode_q);

    gnf_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .se  (se),
        .rst (rst),
        .en  (bus.en),
        .div (bus.div),
        .clr (mode_change),
        .tick(tick)
    );

    // Next step index for an advance, wrapping at either end; direction is
    // only consumed when a tick actually lands.
    always_comb begin
        last_sector = SEC_W'(gnf_steps(PHASES, mode_q) - 1);
        if (bus.dir == GNF_REV) begin
            sector_next = (sector_q == '0) ? last_sector : sector_q - SEC_W'(1);
        end else begin
            sector_next = (sector_q == last_sector) ? '0 : sector_q + SEC_W'(1);
        end
        q_next = PHASES'(gnf_decode(PHASES, int'(sector_next), mode_q));
        q_home = PHASES'(gnf_decode(PHASES, 0, bus.mode));
    end

    // Sequence state: reset beats a mode switch, which beats a tick.
    always_ff @(posedge se) begin
        if (rst) begin
            mode_q   <= bus.mode;
            sector_q <= '0;
            q_q      <= q_home;
            step_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else if (mode_change) begin
            mode_q   <= bus.mode;
            sector_q <= '0;
            q_q      <= q_home;
            step_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else if (tick) begin
            sector_q <= sector_next;
            q_q      <= q_next;
            step_q   <= 1'b1;
            sync_q   <= (sector_next == '0);
        end else begin
            step_q   <= 1'b0;
            sync_q   <= 1'b0;
        end
    end

    assign bus.q      = q_q;
    assign bus.qn     = ~q_q;
    assign bus.sector = sector_q;
    assign bus.step   = step_q;
    assign bus.sync   = sync_q;

endmodule

// File: tb/tb_gnf_phase_gen.sv
// Self-checking bench for gnf_phase_gen: directed vector table, a few
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_gnf_phase_gen;

    localparam int PHASES = 3;
    localparam int DIV_W  = 8;
    localparam int MASK   = (1 << PHASES) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gnf_phase_gen_if #(.PHASES(PHASES), .DIV_W(DIV_W)) bus ();

    gnf_phase_gen #(.PHASES(PHASES), .DIV_W(DIV_W)) dut (
        .se (clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_sec  = 0;
    int m_cnt  = 0;
    bit m_mode = 1'b0;
    bit m_step = 1'b0;
    bit m_sync = 1'b0;

    typedef struct {
        bit rst;
        bit en;
        bit dir;
        bit mode;
        int div;
        int q;
        int sector;
        bit step;
        bit sync;
    } vec_t;

    vec_t vecs[$];

    // Expected phase pattern from the step index using plain arithmetic:
    // Johnson fills ones from bit 0 then drains them from bit 0.
    function automatic int expPattern(int s, bit mode);
        if (mode) return (1 << s);
        if (s <= PHASES) return (1 << s) - 1;
        return MASK & ~((1 << (s - PHASES)) - 1);
    endfunction

    // Model of one clock edge.
    function automatic void modelStep(bit r, bit e, bit d, bit m, int dv);
        int len;
        m_step = 1'b0;
        m_sync = 1'b0;
        if (r) begin
            m_mode = m;
            m_sec  = 0;
            m_cnt  = 0;
        end else if (m != m_mode) begin
            m_mode = m;
            m_sec  = 0;
            m_cnt  = 0;
        end else if (e) begin
            if (m_cnt >= dv) begin
                m_cnt  = 0;
                len    = m_mode ? PHASES : 2 * PHASES;
                m_sec  = d ? (m_sec + len - 1) % len : (m_sec + 1) % len;
                m_step = 1'b1;
                m_sync = (m_sec == 0);
            end else begin
                m_cnt = (m_cnt + 1) % (1 << DIV_W);
            end
        end
    endfunction

    function automatic void addVec(bit r, bit e, bit d, bit m, int dv,
                                   int q, int s, bit st, bit sy);
        vec_t v;
        v.rst = r; v.en = e; v.dir = d; v.mode = m; v.div = dv;
        v.q = q; v.sector = s; v.step = st; v.sync = sy;
        vecs.push_back(v);
    endfunction

    task automatic checkEq(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs, clock once, advance the model, settle.
    task automatic applyStimulus(bit r, bit e, bit d, bit m, int dv);
        rst      = r;
        bus.en   = e;
        bus.dir  = d;
        bus.mode = m;
        bus.div  = DIV_W'(dv);
        @(posedge clk);
        modelStep(r, e, d, m, dv);
        #1;
    endtask

    // Compare every output against the model.
    task automatic checkOutput(string tag);
        int eq;
        eq = expPattern(m_sec, m_mode);
        checkEq({tag, " q"},      int'(bus.q),      eq);
        checkEq({tag, " qn"},     int'(bus.qn),     (~eq) & MASK);
        checkEq({tag, " sector"}, int'(bus.sector), m_sec);
        checkEq({tag, " step"},   int'(bus.step),   int'(m_step));
        checkEq({tag, " sync"},   int'(bus.sync),   int'(m_sync));
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bit cur_mode;
        bit cur_dir;
        int cur_div;
        bit r;
        bit e;

        // rst en dir mode div | q sector step sync
        addVec(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 3'b000, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 3'b001, 1, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b011, 2, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b111, 3, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b110, 4, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b100, 5, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b000, 0, 1, 1);
        addVec(0, 1, 0, 0, 0, 3'b001, 1, 1, 0);
        addVec(0, 1, 0, 0, 0, 3'b011, 2, 1, 0);
        addVec(0, 1, 1, 0, 0, 3'b001, 1, 1, 0);
        addVec(0, 1, 1, 0, 0, 3'b000, 0, 1, 1);
        addVec(0, 1, 1, 0, 0, 3'b100, 5, 1, 0);
        addVec(0, 1, 1, 0, 0, 3'b110, 4, 1, 0);
        addVec(0, 1, 0, 1, 0, 3'b001, 0, 0, 0);
        addVec(0, 1, 0, 1, 0, 3'b010, 1, 1, 0);
        addVec(0, 1, 0, 1, 0, 3'b100, 2, 1, 0);
        addVec(0, 1, 0, 1, 0, 3'b001, 0, 1, 1);
        addVec(1, 1, 0, 1, 0, 3'b001, 0, 0, 0);
        addVec(0, 1, 0, 1, 0, 3'b010, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].div);
            checkEq($sformatf("vec%0d q", i),      int'(bus.q),      vecs[i].q);
            checkEq($sformatf("vec%0d qn", i),     int'(bus.qn),     (~vecs[i].q) & MASK);
            checkEq($sformatf("vec%0d sector", i), int'(bus.sector), vecs[i].sector);
            checkEq($sformatf("vec%0d step", i),   int'(bus.step),   int'(vecs[i].step));
            checkEq($sformatf("vec%0d sync", i),   int'(bus.sync),   int'(vecs[i].sync));
        end

        // DIV=3: one advance every 4 enabled clocks from reset
        applyStimulus(1, 0, 0, 0, 3);
        checkOutput("div3 reset");
        n = 0;
        do begin
            applyStimulus(0, 1, 0, 0, 3);
            checkOutput("div3 run");
            n++;
        end while (!bus.step && n < 50);
        checkEq("div3 period", n, 4);

        // EN dropped for 5 clocks mid-count delays the advance by exactly 5
        applyStimulus(0, 1, 0, 0, 3);
        checkOutput("gap pre");
        repeat (5) begin
            applyStimulus(0, 0, 0, 0, 3);
            checkOutput("gap hold");
        end
        n = 0;
        do begin
            applyStimulus(0, 1, 0, 0, 3);
            checkOutput("gap run");
            n++;
        end while (!bus.step && n < 50);
        checkEq("en gap period", 1 + 5 + n, 9);

        // DIV lowered below the running count ticks on the next clock
        repeat (4) begin
            applyStimulus(0, 1, 0, 0, 5);
            checkOutput("div5 count");
        end
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("div lowered");
        checkEq("div lowered step", int'(bus.step), 1);

        // MODE change while disabled still restarts the sequence
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("mode en0");
        checkEq("mode en0 sector", int'(bus.sector), 0);
        checkEq("mode en0 q", int'(bus.q), 3'b001);

        // Tick and MODE change on the same edge: mode change wins
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("ring advance");
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("mode vs tick");
        checkEq("mode vs tick step", int'(bus.step), 0);
        checkEq("mode vs tick q", int'(bus.q), 3'b000);

        // Randomized run against the model
        cur_mode = 1'b0;
        cur_dir  = 1'b0;
        cur_div  = 0;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(63) == 0);
            if ($urandom_range(31) == 0) cur_mode = ~cur_mode;
            if ($urandom_range(15) == 0) cur_dir = ~cur_dir;
            if ($urandom_range(7) == 0) cur_div = $urandom_range(4);
            e = ($urandom_range(3) != 0);
            applyStimulus(r, e, cur_dir, cur_mode, cur_div);
            checkOutput("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
